// File: rtl/sequence_receiver.sv
// Serial frame receiver: collects WIDTH bits MSB-first, compares each completed
// frame against a programmed pattern and keeps a wrapping decimal match count.
module sequence_receiver #(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned COUNT_MAX = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             pause,
  input  logic [WIDTH-1:0] pattern,
  output logic [WIDTH-1:0] sequence_reg,
  output logic             frame_done,
  output logic             match,
  output logic [3:0]       match_count,
  output logic [3:0]       bit_index
);

  localparam logic [3:0] LAST_IDX = 4'(WIDTH - 1);
  localparam logic [3:0] CNT_MAX  = 4'(COUNT_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Only WIDTH-1 bits are stored; the final bit arrives live on bit_in.
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [WIDTH-1:0] frame_c;
  logic             last_bit_c;

  logic [WIDTH-1:0] sequence_d;
  logic             frame_done_d;
  logic             match_d;
  logic [3:0]       match_count_d;
  logic [3:0]       bit_index_d;

  assign frame_c    = {shift_q, bit_in};
  assign last_bit_c = bit_valid && (state == RECV) && (bit_index == LAST_IDX);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else if (pause) begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bit_valid) state_next = RECV;
      RECV:    if (last_bit_c) state_next = DONE;
      DONE:    state_next = bit_valid ? RECV : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the datapath / output registers
  always_comb begin
    shift_d       = shift_q;
    sequence_d    = sequence_reg;
    frame_done_d  = 1'b0;
    match_d       = match;
    match_count_d = match_count;
    bit_index_d   = bit_index;
    if (bit_valid) begin
      shift_d = frame_c[WIDTH-2:0];
    end
    case (state)
      IDLE, DONE: bit_index_d = bit_valid ? 4'd1 : 4'd0;
      RECV: begin
        if (last_bit_c) begin
          sequence_d   = frame_c;
          frame_done_d = 1'b1;
          match_d      = (frame_c == pattern);
          bit_index_d  = 4'd0;
          if (frame_c == pattern) begin
            match_count_d = (match_count == CNT_MAX) ? 4'd0 : match_count + 4'd1;
          end
        end else if (bit_valid) begin
          bit_index_d = bit_index + 4'd1;
        end
      end
      default: bit_index_d = 4'd0;
    endcase
  end

  // Datapath registers; pause holds everything except the frame_done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q      <= '0;
      sequence_reg <= '0;
      frame_done   <= 1'b0;
      match        <= 1'b0;
      match_count  <= 4'd0;
      bit_index    <= 4'd0;
    end else if (!pause) begin
      frame_done   <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      sequence_reg <= sequence_d;
      frame_done   <= frame_done_d;
      match        <= match_d;
      match_count  <= match_count_d;
      bit_index    <= bit_index_d;
    end
  end

endmodule

// File: tb/tb_sequence_receiver.sv
// Self-checking bench for sequence_receiver: directed scenarios plus random
// traffic, all compared every cycle against a bit-counting reference model.
module tb_sequence_receiver;

  localparam int W    = 10;
  localparam int CMAX = 9;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         bit_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         pause = 1'b1;
  logic [W-1:0] pattern = '0;
  logic [W-1:0] sequence_reg;
  logic         frame_done;
  logic         match;
  logic [3:0]   match_count;
  logic [3:0]   bit_index;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  int           m_nbits = 0;
  logic [W-1:0] m_frame = '0;
  logic [W-1:0] m_seq   = '0;
  logic         m_done  = 1'b0;
  logic         m_match = 1'b0;
  int           m_count = 0;

  sequence_receiver #(.WIDTH(W), .COUNT_MAX(CMAX)) dut (
    .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .pause(pause), .pattern(pattern), .sequence_reg(sequence_reg),
    .frame_done(frame_done), .match(match), .match_count(match_count),
    .bit_index(bit_index)
  );

  always #5 clock = ~clock;

  // Model: count accepted bits; every W-th bit closes a frame.
  always @(posedge clock) begin
    if (reset) begin
      m_nbits = 0; m_frame = '0; m_seq = '0; m_done = 1'b0; m_match = 1'b0; m_count = 0;
    end else begin
      m_done = 1'b0;
      if (pause && bit_valid) begin
        m_frame = {m_frame[W-2:0], bit_in};
        m_nbits = m_nbits + 1;
        if (m_nbits == W) begin
          m_seq   = m_frame;
          m_done  = 1'b1;
          m_match = (m_frame == pattern);
          if (m_match) m_count = (m_count + 1) % (CMAX + 1);
          m_nbits = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clock) begin
    if (chk_en) begin
      chk("model sequence_reg", int'(sequence_reg), int'(m_seq));
      chk("model frame_done",   int'(frame_done),   int'(m_done));
      chk("model match",        int'(match),        int'(m_match));
      chk("model match_count",  int'(match_count),  m_count);
      chk("model bit_index",    int'(bit_index),    m_nbits);
    end
  end

  task automatic drive(input logic r, input logic v, input logic b, input logic p);
    reset = r; bit_valid = v; bit_in = b; pause = p;
    @(posedge clock);
    #1;
  endtask

  task automatic send_bits(input logic [W-1:0] f, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) drive(1'b0, 1'b1, f[i], 1'b1);
  endtask

  initial begin
    logic [W-1:0] f;
    int tx;

    // Reset, then one matching frame
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    chk("reset sequence_reg", int'(sequence_reg), 0);
    chk("reset match_count",  int'(match_count), 0);
    chk("reset bit_index",    int'(bit_index), 0);
    pattern = 10'b1010101010;
    send_bits(10'b1010101010, 9, 1);
    chk("t1 frame_done early", int'(frame_done), 0);
    send_bits(10'b1010101010, 0, 0);
    chk("t1 sequence_reg", int'(sequence_reg), 'h2AA);
    chk("t1 frame_done",   int'(frame_done), 1);
    chk("t1 match",        int'(match), 1);
    chk("t1 match_count",  int'(match_count), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1 pulse width",  int'(frame_done), 0);

    // Mismatch with gaps between valid bits
    pattern = 10'b1100101101;
    f = 10'b1010101010;
    for (int i = 9; i >= 0; i--) begin
      drive(1'b0, 1'b1, f[i], 1'b1);
      chk("t2 bit_index", int'(bit_index), (i == 0) ? 0 : 10 - i);
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      chk("t2 bit_index hold", int'(bit_index), (i == 0) ? 0 : 10 - i);
    end
    chk("t2 match",       int'(match), 0);
    chk("t2 match_count", int'(match_count), 1);
    chk("t2 sequence_reg", int'(sequence_reg), 'h2AA);

    // Back-to-back matching frames, count wraps after 9
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    pattern = 10'h2AA;
    for (int fr = 0; fr < 10; fr++) begin
      for (int i = 9; i >= 0; i--) begin
        drive(1'b0, 1'b1, pattern[i], 1'b1);
        chk("t3 frame_done", int'(frame_done), (i == 0) ? 1 : 0);
      end
      chk("t3 match_count", int'(match_count), (fr + 1) % 10);
    end

    // Pause mid-frame
    pattern = 10'h155;
    f = 10'h155;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(f, 9, 5);
    chk("t4 bit_index before pause", int'(bit_index), 5);
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      chk("t4 bit_index frozen", int'(bit_index), 5);
      chk("t4 frame_done frozen", int'(frame_done), 0);
    end
    send_bits(f, 4, 0);
    chk("t4 sequence_reg", int'(sequence_reg), 'h155);
    chk("t4 frame_done", int'(frame_done), 1);
    chk("t4 match", int'(match), 1);

    // Reset mid-frame
    send_bits(10'h3C5, 9, 4);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5 reset sequence_reg", int'(sequence_reg), 0);
    chk("t5 reset match", int'(match), 0);
    chk("t5 reset match_count", int'(match_count), 0);
    chk("t5 reset bit_index", int'(bit_index), 0);
    chk("t5 reset frame_done", int'(frame_done), 0);
    pattern = 10'b1100101101;
    send_bits(10'b1100101101, 9, 0);
    chk("t5 sequence_reg", int'(sequence_reg), 'h32D);
    chk("t5 match", int'(match), 1);
    chk("t5 match_count", int'(match_count), 1);

    // Pattern changed mid-frame
    pattern = '0;
    f = 10'h1B7;
    send_bits(f, 9, 6);
    pattern = f;
    send_bits(f, 5, 0);
    chk("t6 match", int'(match), 1);
    chk("t6 match_count", int'(match_count), 2);

    // Random traffic: mostly transmit the pattern so matches occur often
    tx = 0;
    for (int c = 0; c < 3000; c++) begin
      logic r, v, p, b;
      if ($urandom_range(0, 59) == 0) pattern = W'($urandom);
      r = ($urandom_range(0, 149) == 0);
      v = ($urandom_range(0, 3) != 0);
      p = ($urandom_range(0, 7) != 0);
      b = pattern[W - 1 - (tx % W)];
      if ($urandom_range(0, 15) == 0) b = ~b;
      drive(r, v, b, p);
      if (r) tx = 0;
      else if (v && p) tx++;
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
